// File: rtl/rf_pkg.sv
// Shared types and helpers for the multi-read, dual-write register file.
// Optional feature macro used by the top level: RF_BYPASS_EN.
package rf_pkg;

   // Control FSM states: sweeping the array to zero, or open for writes.
   typedef enum logic [0:0] {
      RF_CLEAR = 1'b0,
      RF_READY = 1'b1
   } rf_state_e;

   localparam int RF_NWRITE = 2;

   // Lane-priority select: given per-lane hits, returns a one-hot lane
   // choice where lane 1 overrides lane 0. Used by the array write path
   // and by the read bypass so both agree on the winner of a collision.
   function automatic logic [RF_NWRITE-1:0] rf_lane_sel(input logic [RF_NWRITE-1:0] hit);
      logic [RF_NWRITE-1:0] sel;
      if (hit[1]) begin
         sel = 2'b10;
      end else if (hit[0]) begin
         sel = 2'b01;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

endpackage

// File: rtl/rf_clear_ctrl.sv
// Clear/ready control for the register file: owns the FSM and the sweep
// counter that zeroes every entry after reset or a runtime clear request.
module rf_clear_ctrl
   import rf_pkg::*;
#(
   parameter int ALEN = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_clear,
   output logic            o_ready,
   output logic            o_clr_we,
   output logic [ALEN-1:0] o_clr_addr
);

   rf_state_e       state_r;
   logic [ALEN-1:0] cnt_r;

   // FSM and sweep counter; the last entry hands over to READY and cnt wraps to 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= RF_CLEAR;
         cnt_r   <= {ALEN{1'b0}};
      end else begin
         case (state_r)
            RF_CLEAR: begin
               cnt_r <= cnt_r + {{(ALEN-1){1'b0}}, 1'b1};
               if (&cnt_r) begin
                  state_r <= RF_READY;
               end else begin
                  state_r <= RF_CLEAR;
               end
            end
            RF_READY: begin
               if (i_clear) begin
                  state_r <= RF_CLEAR;
                  cnt_r   <= {ALEN{1'b0}};
               end else begin
                  state_r <= RF_READY;
                  cnt_r   <= cnt_r;
               end
            end
            default: begin
               state_r <= RF_CLEAR;
               cnt_r   <= {ALEN{1'b0}};
            end
         endcase
      end
   end

   assign o_ready    = (state_r == RF_READY);
   // A reset edge must not write the array, even if the FSM is sweeping.
   assign o_clr_we   = (state_r == RF_CLEAR) & ~rst;
   assign o_clr_addr = cnt_r;

endmodule

// File: rtl/regfile_mr2w.sv
// Multi-read, dual-write register file with collision priority (lane 1
// wins), optional hardwired-zero entry 0 and a self-clearing sweep.
// Define RF_BYPASS_EN to forward same-cycle write data to matching reads.
module regfile_mr2w
   import rf_pkg::*;
#(
   parameter int ALEN     = 5,
   parameter int DLEN     = 32,
   parameter int NREAD    = 4,
   parameter int ZERO_REG = 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             i_clear,
   output logic                             o_ready,
   input  logic [NREAD-1:0][ALEN-1:0]       i_raddr,
   output logic [NREAD-1:0][DLEN-1:0]       o_rdata,
   input  logic [RF_NWRITE-1:0]             i_wen,
   input  logic [RF_NWRITE-1:0][ALEN-1:0]   i_waddr,
   input  logic [RF_NWRITE-1:0][DLEN-1:0]   i_wdata
);

   localparam int DEPTH = 2 ** ALEN;

   logic                      ready_s;
   logic                      clr_we_s;
   logic [ALEN-1:0]           clr_addr_s;
   logic                      wr_ok_s;
   logic [RF_NWRITE-1:0]      wsel_s [DEPTH];
   logic [NREAD-1:0][DLEN-1:0] rdata_s;
   logic [DLEN-1:0]           mem_r [DEPTH];
`ifdef RF_BYPASS_EN
   logic [RF_NWRITE-1:0]      byp_sel_s [NREAD];
`endif

   rf_clear_ctrl #(.ALEN(ALEN)) u_clear_ctrl (
      .clk        (clk),
      .rst        (rst),
      .i_clear    (i_clear),
      .o_ready    (ready_s),
      .o_clr_we   (clr_we_s),
      .o_clr_addr (clr_addr_s)
   );

   assign o_ready = ready_s;
   // Lane writes only land in READY, and not on a clear-request or reset edge.
   assign wr_ok_s = ready_s & ~i_clear & ~rst;

   // Per-entry winning lane; entry 0 is never written when it is hardwired zero.
   always_comb begin
      for (int e = 0; e < DEPTH; e++) begin
         wsel_s[e] = 2'b00;
         if ((ZERO_REG != 0) && (e == 0)) begin
            wsel_s[e] = 2'b00;
         end else begin
            wsel_s[e] = rf_lane_sel({wr_ok_s & i_wen[1] & (i_waddr[1] == ALEN'(e)),
                                     wr_ok_s & i_wen[0] & (i_waddr[0] == ALEN'(e))});
         end
      end
   end

   // Array update: the sweep zeroes one entry per edge, otherwise the selected lane writes.
   always_ff @(posedge clk) begin
      for (int e = 0; e < DEPTH; e++) begin
         if (clr_we_s && (clr_addr_s == ALEN'(e))) begin
            mem_r[e] <= {DLEN{1'b0}};
         end else if (wsel_s[e][1]) begin
            mem_r[e] <= i_wdata[1];
         end else if (wsel_s[e][0]) begin
            mem_r[e] <= i_wdata[0];
         end else begin
            mem_r[e] <= mem_r[e];
         end
      end
   end

   // Combinational read ports: zero while clearing or for entry 0, optional bypass.
   always_comb begin
      rdata_s = {(NREAD*DLEN){1'b0}};
`ifdef RF_BYPASS_EN
      for (int p = 0; p < NREAD; p++) begin
         byp_sel_s[p] = rf_lane_sel({wr_ok_s & i_wen[1] & (i_waddr[1] == i_raddr[p]),
                                     wr_ok_s & i_wen[0] & (i_waddr[0] == i_raddr[p])});
      end
`endif
      for (int p = 0; p < NREAD; p++) begin
         if (!ready_s) begin
            rdata_s[p] = {DLEN{1'b0}};
         end else if ((ZERO_REG != 0) && (i_raddr[p] == {ALEN{1'b0}})) begin
            rdata_s[p] = {DLEN{1'b0}};
`ifdef RF_BYPASS_EN
         end else if (byp_sel_s[p][1]) begin
            rdata_s[p] = i_wdata[1];
         end else if (byp_sel_s[p][0]) begin
            rdata_s[p] = i_wdata[0];
`endif
         end else begin
            rdata_s[p] = mem_r[i_raddr[p]];
         end
      end
   end

   assign o_rdata = rdata_s;

endmodule

// File: tb/tb_regfile_mr2w.sv
// Scoreboard bench for regfile_mr2w: stimulus pushes expected values for the
// current cycle, a negedge monitor pops and compares them against the DUT.
module tb_regfile_mr2w;

   localparam int ALEN  = 5;
   localparam int DLEN  = 32;
   localparam int NREAD = 4;
   localparam int DEPTH = 32;

   logic                        clk;
   logic                        rst;
   logic                        i_clear;
   logic                        o_ready;
   logic [NREAD-1:0][ALEN-1:0]  i_raddr;
   logic [NREAD-1:0][DLEN-1:0]  o_rdata;
   logic [1:0]                  i_wen;
   logic [1:0][ALEN-1:0]        i_waddr;
   logic [1:0][DLEN-1:0]        i_wdata;

   int checks   = 0;
   int failures = 0;

   // Scoreboard queues: kind 0 = o_ready, kind 1 = o_rdata[port].
   int          q_kind [$];
   int          q_port [$];
   logic [31:0] q_exp  [$];
   string       q_name [$];

   int          m_kind;
   int          m_port;
   logic [31:0] m_exp;
   logic [31:0] m_act;
   string       m_name;

   regfile_mr2w #(.ALEN(ALEN), .DLEN(DLEN), .NREAD(NREAD), .ZERO_REG(1)) dut (
      .clk     (clk),
      .rst     (rst),
      .i_clear (i_clear),
      .o_ready (o_ready),
      .i_raddr (i_raddr),
      .o_rdata (o_rdata),
      .i_wen   (i_wen),
      .i_waddr (i_waddr),
      .i_wdata (i_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: compare every pending expectation away from the active edge.
   always @(negedge clk) begin
      while (q_kind.size() > 0) begin
         m_kind = q_kind.pop_front();
         m_port = q_port.pop_front();
         m_exp  = q_exp.pop_front();
         m_name = q_name.pop_front();
         if (m_kind == 0) m_act = {31'b0, o_ready};
         else             m_act = o_rdata[m_port];
         checks = checks + 1;
         if (m_act !== m_exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %h expected %h", m_name, m_act, m_exp);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_rdy(input logic v, input string nm);
      q_kind.push_back(0); q_port.push_back(0);
      q_exp.push_back({31'b0, v}); q_name.push_back(nm);
   endtask

   task automatic exp_rd(input int p, input logic [31:0] v, input string nm);
      q_kind.push_back(1); q_port.push_back(p);
      q_exp.push_back(v); q_name.push_back(nm);
   endtask

   task automatic set_all_raddr(input int a);
      for (int p = 0; p < NREAD; p++) i_raddr[p] = 5'(a);
   endtask

   function automatic logic [31:0] fill_val(input int a);
      return 32'hFFFF_FF00 | 32'(32 - a);
   endfunction

   // Expect o_ready=0 and zero reads for DEPTH edges, then o_ready=1.
   task automatic sweep_checks(input string tag);
      for (int k = 0; k < DEPTH; k++) begin
         for (int p = 0; p < NREAD; p++) begin
            i_raddr[p] = 5'((k + p * 8) % DEPTH);
            exp_rd(p, 32'h0, $sformatf("%s_rd k=%0d p=%0d", tag, k, p));
         end
         exp_rdy(1'b0, $sformatf("%s_rdy k=%0d", tag, k));
         step();
      end
      exp_rdy(1'b1, $sformatf("%s_rdy_done", tag));
   endtask

   task automatic read_all_zero(input string tag);
      for (int a = 0; a < DEPTH; a++) begin
         set_all_raddr(a);
         for (int p = 0; p < NREAD; p++)
            exp_rd(p, 32'h0, $sformatf("%s a=%0d p=%0d", tag, a, p));
         step();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; i_clear = 1'b0; i_wen = 2'b00;
      i_waddr = '0; i_wdata = '0; i_raddr = '0;

      // Reset held 3 cycles.
      for (int k = 0; k < 3; k++) begin
         step();
         exp_rdy(1'b0, "reset_rdy");
         exp_rd(0, 32'h0, "reset_rd");
      end
      step();
      rst = 1'b0;
      sweep_checks("init");
      read_all_zero("init_zero");

      // Fill 1..31 via lane 0; also try to write entry 0 (must be dropped).
      for (int i = 1; i < DEPTH; i++) begin
         i_wen = 2'b01; i_waddr[0] = 5'(i); i_wdata[0] = fill_val(i);
         step();
      end
      i_wen = 2'b01; i_waddr[0] = 5'd0; i_wdata[0] = 32'hCAFE_F00D;
      step();
      i_wen = 2'b00;
      for (int a = 0; a < DEPTH; a++) begin
         set_all_raddr(a);
         for (int p = 0; p < NREAD; p++)
            exp_rd(p, (a == 0) ? 32'h0 : fill_val(a), $sformatf("fill a=%0d p=%0d", a, p));
         step();
      end

      // Same-address collision: lane 1 wins.
      i_wen = 2'b11;
      i_waddr[0] = 5'd7; i_wdata[0] = 32'hAAAA_5555;
      i_waddr[1] = 5'd7; i_wdata[1] = 32'h1234_5678;
      set_all_raddr(7);
`ifdef RF_BYPASS_EN
      exp_rd(0, 32'h1234_5678, "collide_same_cycle");
`else
      exp_rd(0, fill_val(7), "collide_same_cycle");
`endif
      step();
      i_wen = 2'b00;
      for (int p = 0; p < NREAD; p++) exp_rd(p, 32'h1234_5678, $sformatf("collide p=%0d", p));
      step();

      // Two lanes to distinct addresses both land.
      i_wen = 2'b11;
      i_waddr[0] = 5'd4; i_wdata[0] = 32'h0000_0044;
      i_waddr[1] = 5'd5; i_wdata[1] = 32'h0000_0055;
      step();
      i_wen = 2'b00;
      i_raddr[0] = 5'd4; i_raddr[1] = 5'd5; i_raddr[2] = 5'd6; i_raddr[3] = 5'd0;
      exp_rd(0, 32'h0000_0044, "dual_lane0");
      exp_rd(1, 32'h0000_0055, "dual_lane1");
      exp_rd(2, fill_val(6), "dual_untouched");
      exp_rd(3, 32'h0, "dual_zero_reg");
      step();

      // Write-to-read latency on address 9 through port 2.
      i_wen = 2'b01; i_waddr[0] = 5'd9; i_wdata[0] = 32'hDEAD_BEEF;
      i_raddr[2] = 5'd9;
`ifdef RF_BYPASS_EN
      exp_rd(2, 32'hDEAD_BEEF, "bypass_same_cycle");
`else
      exp_rd(2, fill_val(9), "nobypass_same_cycle");
`endif
      step();
      i_wen = 2'b00;
      exp_rd(2, 32'hDEAD_BEEF, "write_next_cycle");
      step();

      // Runtime clear with a simultaneous (dropped) write to address 3.
      i_clear = 1'b1; i_wen = 2'b01; i_waddr[0] = 5'd3; i_wdata[0] = 32'h0000_0001;
      set_all_raddr(3);
      exp_rdy(1'b1, "clear_req_rdy");
      exp_rd(0, fill_val(3), "clear_req_rd");
      step();
      i_clear = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         i_wen = 2'b11;
         i_waddr[0] = 5'(k); i_wdata[0] = 32'h5A5A_0000 | 32'(k);
         i_waddr[1] = 5'(31 - k); i_wdata[1] = 32'hA5A5_0000 | 32'(k);
         i_clear = (k == 5) ? 1'b1 : 1'b0;
         for (int p = 0; p < NREAD; p++) begin
            i_raddr[p] = 5'((k + p) % DEPTH);
            exp_rd(p, 32'h0, $sformatf("clr_rd k=%0d p=%0d", k, p));
         end
         exp_rdy(1'b0, $sformatf("clr_rdy k=%0d", k));
         step();
      end
      i_wen = 2'b00; i_clear = 1'b0;
      exp_rdy(1'b1, "clr_rdy_done");
      read_all_zero("clr_zero");

      // Reset at sweep count 10 restarts the sweep.
      i_wen = 2'b01; i_waddr[0] = 5'd31; i_wdata[0] = 32'h0000_0031;
      step();
      i_wen = 2'b00; i_clear = 1'b1;
      step();
      i_clear = 1'b0;
      for (int k = 0; k < 10; k++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      sweep_checks("rst_mid");
      read_all_zero("rst_mid_zero");

      if (q_kind.size() != 0) begin
         failures = failures + 1;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", q_kind.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
